// File: rtl/q_mul_core_n.sv
// Multi-lane quantised multiplier: C = sat(round((A*B*SCALE) >>> SHIFT)) with valid/ready.
// Operands are registered on accept, then multiply, scale and round/saturate stages follow.
module q_mul_core_n #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 4,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [LANES*DATA_W-1:0]   A_IN,
    input  logic [LANES*DATA_W-1:0]   B_IN,
    input  logic [SCALE_W-1:0]        SCALE_IN,
    input  logic [SHIFT_W-1:0]        SHIFT_IN,
    input  logic                      MODE_IN,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic [LANES*DATA_W-1:0]   C_OUT,
    output logic [LANES-1:0]          SAT_OUT
);

    localparam int P1_W  = 2 * DATA_W;
    localparam int P2_W  = P1_W + SCALE_W;
    localparam int SUM_W = P2_W + 1;

    localparam logic signed [SUM_W-1:0] MAX_R = SUM_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_R = -SUM_W'(2 ** (DATA_W - 1));
    localparam logic [DATA_W-1:0]       C_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]       C_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic adv;

    logic                     v0;
    logic [LANES*DATA_W-1:0]  a0;
    logic [LANES*DATA_W-1:0]  b0;
    logic [SCALE_W-1:0]       scale0;
    logic [SHIFT_W-1:0]       shift0;
    logic                     mode0;

    logic                     v1;
    logic signed [P1_W-1:0]   p1 [LANES];
    logic [SCALE_W-1:0]       scale1;
    logic [SHIFT_W-1:0]       shift1;
    logic                     mode1;

    logic                     v2;
    logic signed [P2_W-1:0]   p2 [LANES];
    logic [SHIFT_W-1:0]       shift2;
    logic                     mode2;

    logic signed [P1_W-1:0]   p1_next [LANES];
    logic signed [P2_W-1:0]   p2_next [LANES];
    logic [LANES*DATA_W-1:0]  c_next;
    logic [LANES-1:0]         sat_next;
    logic [SUM_W-1:0]         rnd;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  rounded;

    function automatic logic signed [P1_W-1:0] sext_op(input logic [DATA_W-1:0] x);
        return {{DATA_W{x[DATA_W-1]}}, x};
    endfunction

    // The whole pipeline moves as one: any stall at the output freezes every stage.
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            p1_next[i] = sext_op(a0[i*DATA_W +: DATA_W]) * sext_op(b0[i*DATA_W +: DATA_W]);
            p2_next[i] = {{SCALE_W{p1[i][P1_W-1]}}, p1[i]}
                       * $signed({{P1_W{scale1[SCALE_W-1]}}, scale1});
        end
    end

    // Rounding adds half an LSB of the shifted result; the sum is one bit wider than P2.
    always_comb begin
        rnd      = '0;
        sum      = '0;
        rounded  = '0;
        c_next   = '0;
        sat_next = '0;
        if (shift2 != '0) begin
            rnd = SUM_W'(1) << (shift2 - SHIFT_W'(1));
        end
        for (int i = 0; i < LANES; i++) begin
            sum     = {p2[i][P2_W-1], p2[i]} + rnd;
            rounded = sum >>> shift2;
            if (mode2) begin
                c_next[i*DATA_W +: DATA_W] = DATA_W'(p2[i] >>> shift2);
            end else if (rounded > MAX_R) begin
                c_next[i*DATA_W +: DATA_W] = C_MAX;
                sat_next[i]                = 1'b1;
            end else if (rounded < MIN_R) begin
                c_next[i*DATA_W +: DATA_W] = C_MIN;
                sat_next[i]                = 1'b1;
            end else begin
                c_next[i*DATA_W +: DATA_W] = rounded[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            OUT_VALID <= 1'b0;
            C_OUT     <= '0;
            SAT_OUT   <= '0;
        end else if (adv) begin
            v0        <= IN_VALID;
            v1        <= v0;
            v2        <= v1;
            OUT_VALID <= v2;
            C_OUT     <= c_next;
            SAT_OUT   <= sat_next;
        end
    end

    // Datapath registers need no reset; the valid bits decide what is meaningful.
    always_ff @(posedge CLK) begin
        if (adv) begin
            a0     <= A_IN;
            b0     <= B_IN;
            scale0 <= SCALE_IN;
            shift0 <= SHIFT_IN;
            mode0  <= MODE_IN;
            p1     <= p1_next;
            scale1 <= scale0;
            shift1 <= shift0;
            mode1  <= mode0;
            p2     <= p2_next;
            shift2 <= shift1;
            mode2  <= mode1;
        end
    end

endmodule

// File: tb/tb_q_mul_core_n.sv
// Self-checking bench for q_mul_core_n: directed cases plus random beats against a
// queue-based arithmetic model of the multiplier.
module tb_q_mul_core_n;

    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] A_IN;
    logic [31:0] B_IN;
    logic [15:0] SCALE_IN;
    logic [4:0]  SHIFT_IN;
    logic        MODE_IN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] C_OUT;
    logic [3:0]  SAT_OUT;

    int checks = 0;
    int errors = 0;
    bit randomReady = 0;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  sat;
        int          age;
    } beat_t;

    beat_t      model[$];
    logic [7:0] seen[$];
    bit         checkZeros = 0;
    bit         holdValid = 0;
    logic [31:0] holdC;
    logic [3:0]  holdSat;

    q_mul_core_n dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A_IN(A_IN), .B_IN(B_IN), .SCALE_IN(SCALE_IN), .SHIFT_IN(SHIFT_IN),
        .MODE_IN(MODE_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .C_OUT(C_OUT), .SAT_OUT(SAT_OUT)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Plain integer arithmetic version of the quantised multiply, one beat at a time.
    function automatic void modelBeat(input logic [31:0] a, input logic [31:0] b,
                                      input logic [15:0] sc, input logic [4:0] sh,
                                      input logic md, output logic [31:0] c,
                                      output logic [3:0] s);
        longint pa, pb, p, r;
        c = '0;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            pa = $signed(a[i*8 +: 8]);
            pb = $signed(b[i*8 +: 8]);
            p  = pa * pb * longint'($signed(sc));
            if (md) begin
                r = p >>> sh;
                c[i*8 +: 8] = r[7:0];
            end else begin
                r = (sh == 0) ? p : ((p + (longint'(1) << (sh - 1))) >>> sh);
                if (r > 127) begin
                    c[i*8 +: 8] = 8'h7F;
                    s[i] = 1'b1;
                end else if (r < -128) begin
                    c[i*8 +: 8] = 8'h80;
                    s[i] = 1'b1;
                end else begin
                    c[i*8 +: 8] = r[7:0];
                end
            end
        end
    endfunction

    function automatic logic [31:0] rep4(input int v);
        logic [7:0] t;
        t = v[7:0];
        return {4{t}};
    endfunction

    // Each model entry counts the advancing edges since it was accepted; it is due at the
    // output once it has seen four of them (accept edge plus three more).
    always @(negedge CLK) begin
        beat_t nb;
        bit adv;
        if (checkZeros) begin
            checkZeros = 0;
            checkOutput("post-reset out_valid", OUT_VALID, 0);
            checkOutput("post-reset c_out", C_OUT, 0);
            checkOutput("post-reset sat_out", SAT_OUT, 0);
        end
        if (RESET) begin
            model.delete();
            checkZeros = 1;
            holdValid = 0;
        end else begin
            checkOutput("out_valid", OUT_VALID, (model.size() > 0 && model[0].age >= 4));
            checkOutput("in_ready", IN_READY, (!OUT_VALID || OUT_READY));
            if (OUT_VALID && model.size() > 0) begin
                checkOutput("c_out", C_OUT, model[0].c);
                checkOutput("sat_out", SAT_OUT, model[0].sat);
            end
            if (holdValid) begin
                checkOutput("stall c_out stable", C_OUT, holdC);
                checkOutput("stall sat_out stable", SAT_OUT, holdSat);
            end
            holdValid = OUT_VALID && !OUT_READY;
            holdC = C_OUT;
            holdSat = SAT_OUT;
            adv = !OUT_VALID || OUT_READY;
            if (OUT_VALID && OUT_READY && model.size() > 0) begin
                seen.push_back(C_OUT[7:0]);
                void'(model.pop_front());
            end
            if (IN_VALID && IN_READY) begin
                modelBeat(A_IN, B_IN, SCALE_IN, SHIFT_IN, MODE_IN, nb.c, nb.sat);
                nb.age = 0;
                model.push_back(nb);
            end
            if (adv) begin
                foreach (model[i]) model[i].age++;
            end
        end
    end

    // Presents one beat and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [15:0] sc, input logic [4:0] sh, input logic md);
        bit accepted;
        A_IN = a;
        B_IN = b;
        SCALE_IN = sc;
        SHIFT_IN = sh;
        MODE_IN = md;
        IN_VALID = 1;
        for (int k = 0; k < 200; k++) begin
            if (randomReady) OUT_READY = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            accepted = IN_READY;
            @(posedge CLK);
            #1;
            if (accepted) return;
        end
        timeoutFail("accept");
    endtask

    task automatic idle(input int n);
        IN_VALID = 0;
        A_IN = 'x;
        B_IN = 'x;
        SCALE_IN = 'x;
        SHIFT_IN = 'x;
        MODE_IN = 'x;
        repeat (n) begin
            if (randomReady) OUT_READY = ($urandom_range(0, 3) != 0);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic getResult(output logic [31:0] c, output logic [3:0] s, output int cyc);
        c = '0;
        s = '0;
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                c = C_OUT;
                s = SAT_OUT;
                cyc = k - 1;
                @(posedge CLK);
                #1;
                return;
            end
        end
        timeoutFail("result");
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            @(negedge CLK);
            if (model.size() == 0 && !OUT_VALID) begin
                @(posedge CLK);
                #1;
                return;
            end
        end
        timeoutFail("drain");
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] c;
        logic [3:0]  s;
        int          cyc;

        RESET = 1;
        OUT_READY = 1;
        idle(0);
        repeat (3) @(posedge CLK);
        #1;
        RESET = 0;
        @(negedge CLK);
        checkOutput("reset in_ready", IN_READY, 1);
        checkOutput("reset out_valid", OUT_VALID, 0);

        modelBeat(rep4(10), rep4(12), 16'd256, 5'd8, 1'b0, c, s);
        checkOutput("model basic", c, 32'h78787878);
        modelBeat(32'hFF01FD03, rep4(1), 16'd1, 5'd1, 1'b0, c, s);
        checkOutput("model rounding", c, 32'h0001FF02);

        @(posedge CLK);
        #1;
        $display("[TB] basic");
        applyStimulus(rep4(10), rep4(12), 16'd256, 5'd8, 1'b0);
        idle(0);
        getResult(c, s, cyc);
        checkOutput("basic latency", cyc, 3);
        checkOutput("basic c", c, 32'h78787878);
        checkOutput("basic sat", s, 4'b0000);

        $display("[TB] saturation");
        applyStimulus(32'h0000807F, 32'h00007F7F, 16'd1, 5'd0, 1'b0);
        idle(0);
        getResult(c, s, cyc);
        checkOutput("sat c", c, 32'h0000807F);
        checkOutput("sat flags", s, 4'b0011);

        $display("[TB] rounding");
        applyStimulus(32'hFF01FD03, rep4(1), 16'd1, 5'd1, 1'b0);
        idle(0);
        getResult(c, s, cyc);
        checkOutput("round c", c, 32'h0001FF02);
        checkOutput("round sat", s, 4'b0000);

        $display("[TB] raw mode");
        applyStimulus(rep4(127), rep4(127), 16'd1, 5'd0, 1'b1);
        idle(0);
        getResult(c, s, cyc);
        checkOutput("raw c", c, 32'h01010101);
        checkOutput("raw sat", s, 4'b0000);
        applyStimulus(rep4(100), rep4(100), 16'd3, 5'd10, 1'b0);
        applyStimulus(rep4(-7), rep4(9), -16'sd5, 5'd2, 1'b1);
        applyStimulus(rep4(50), rep4(-60), 16'd2, 5'd12, 1'b0);
        idle(0);
        drain();

        $display("[TB] backpressure");
        seen.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) applyStimulus(rep4(k), rep4(1), 16'd1, 5'd0, 1'b0);
                idle(0);
            end
            begin
                repeat (4) @(posedge CLK);
                #1;
                OUT_READY = 0;
                @(negedge CLK);
                checkOutput("bp in_ready held", IN_READY, 0);
                checkOutput("bp out_valid held", OUT_VALID, 1);
                repeat (4) @(posedge CLK);
                #1;
                OUT_READY = 1;
            end
        join
        drain();
        checkOutput("bp count", seen.size(), 8);
        for (int k = 0; k < 8 && k < seen.size(); k++) checkOutput("bp order", seen[k], k);

        $display("[TB] reset mid-stream");
        applyStimulus(rep4(5), rep4(1), 16'd1, 5'd0, 1'b0);
        applyStimulus(rep4(6), rep4(1), 16'd1, 5'd0, 1'b0);
        idle(0);
        RESET = 1;
        @(posedge CLK);
        #1;
        RESET = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checkOutput("reset flush out_valid", OUT_VALID, 0);
        end
        @(posedge CLK);
        #1;
        applyStimulus(rep4(9), rep4(2), 16'd1, 5'd0, 1'b0);
        idle(0);
        getResult(c, s, cyc);
        checkOutput("reset new latency", cyc, 3);
        checkOutput("reset new c", c, 32'h12121212);

        $display("[TB] random");
        randomReady = 1;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [15:0] rs;
            ra = $urandom;
            rb = $urandom;
            rs = 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80808080;
                rb = 32'h80808080;
                rs = 16'h8000;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            applyStimulus(ra, rb, rs, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        idle(0);
        randomReady = 0;
        OUT_READY = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
